// File: rtl/soc_system_pio_pkg.sv
// rtl/soc_system_pio_pkg.sv - shared constants for the PIO register blocks
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam logic [1:0] WARMUP = 2'd3;

endpackage

// File: rtl/soc_system_pio_sync_edge.sv
// rtl/soc_system_pio_sync_edge.sv - 2-flop input synchronizer with per-bit edge select
module soc_system_pio_sync_edge
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign data = sync2;
    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    always_comb begin
        edge_pulse = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_pulse = rise;
            EDGE_FALLING: edge_pulse = fall;
            default:      edge_pulse = rise | fall;
        endcase
    end

endmodule

// File: rtl/soc_system_pio_in.sv
// rtl/soc_system_pio_in.sv - Avalon-MM input PIO with edge capture and masked irq
module soc_system_pio_in
    import soc_system_pio_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               EDGE_TYPE  = EDGE_RISING,
    parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [1:0]       warm_cnt;
    logic             wr_en;
    logic             unused_wdata;

    soc_system_pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .data       (data),
        .edge_pulse (edge_pulse)
    );

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    // Edges are ignored until the synchronizer has refilled after reset.
    assign edge_det = (warm_cnt == WARMUP) ? edge_pulse : '0;
    assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt    <= '0;
            edgecapture <= '0;
            irqmask     <= RESET_MASK;
            irq         <= 1'b0;
        end else begin
            if (warm_cnt != WARMUP) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            edgecapture <= (edgecapture & ~edge_clr) | edge_det;
            if (wr_en && address == ADDR_MASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            irq <= |(edgecapture & irqmask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = data;
            ADDR_MASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edgecapture;
            default:   readdata = '0;
        endcase
    end

endmodule
